hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage that produces and owns the HI/LO architectural registers. It consumes the EX-stage operands and a decoded HI/LO operation, runs multi-cycle arithmetic, and tells the hazard logic when IF/ID/EX must hold. It replaces single-cycle HI/LO writes so the ALU critical path excludes 32×32 multiply and divide.

---
 rtl/hilo_pkg.sv | 31 +++
 rtl/hilo_signfix.sv | 34 +++
 rtl/hilo_muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants for the HI/LO multiply/divide unit.
// Holds the op encodings, the sequencer state type and the default iteration count.
package hilo_pkg;

  localparam int HILO_ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } hilo_state_e;

  // MULT, DIV, MADD and MSUB treat their operands as two's complement
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/hilo_signfix.sv
// hilo_signfix: magnitude extraction of the incoming operands and sign
// restoration of the unsigned iteration result. Shared by multiply and divide.
module hilo_signfix
  import hilo_pkg::*;
(
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        sign_a,
  output logic        sign_b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  input  logic [63:0] raw,
  input  logic        neg_full,
  input  logic        neg_hi,
  input  logic        neg_lo,
  output logic [63:0] fixed
);

  // Operand magnitudes and result negation (full 64-bit for products, per half for quotient/remainder)
  always_comb begin
    sign_a = is_signed & a[31];
    sign_b = is_signed & b[31];
    mag_a  = sign_a ? (~a + 32'd1) : a;
    mag_b  = sign_b ? (~b + 32'd1) : b;
    if (neg_full) begin
      fixed = ~raw + 64'd1;
    end else begin
      fixed[63:32] = neg_hi ? (~raw[63:32] + 32'd1) : raw[63:32];
      fixed[31:0]  = neg_lo ? (~raw[31:0] + 32'd1) : raw[31:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide unit owning HI/LO.
// Optional divider datapath enabled by defining HILO_DIV_EN; without it
// DIV/DIVU are no-ops.
//
// state   | meaning
// IDLE    | accepts Start; MTHI/MTLO write here in one edge
// RUN     | ITER unsigned shift-add / restoring-divide iterations
// FIX     | sign restore, MADD/MSUB accumulate, commit to HI/LO
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int ITER = HILO_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_read,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER);

  hilo_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [2:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
`ifdef HILO_DIV_EN
  logic        dz_q, dz_d;
  logic [32:0] div_trial, div_diff;
  logic [63:0] div_next;
`endif

  logic        sf_signed, sf_sign_a, sf_sign_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] fixed;
  logic        neg_full, neg_hi, neg_lo, is_div, accept_op;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, step;

  hilo_signfix u_signfix (
    .is_signed (sf_signed),
    .a         (a),
    .b         (b),
    .sign_a    (sf_sign_a),
    .sign_b    (sf_sign_b),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .raw       (work_q),
    .neg_full  (neg_full),
    .neg_hi    (neg_hi),
    .neg_lo    (neg_lo),
    .fixed     (fixed)
  );

  // Iteration datapath: one shift-add or restoring-divide step per RUN cycle
  always_comb begin
    sf_signed = op_is_signed(op);
    mul_sum   = {1'b0, work_q[63:32]} + {1'b0, (work_q[0] ? dvsr_q : 32'd0)};
    mul_next  = {mul_sum, work_q[31:1]};
`ifdef HILO_DIV_EN
    // work_q holds {remainder, quotient/dividend}; divide-by-zero falls out as all-ones quotient
    div_trial = work_q[63:31];
    div_diff  = div_trial - {1'b0, dvsr_q};
    div_next  = div_diff[32] ? {div_trial[31:0], work_q[30:0], 1'b0}
                             : {div_diff[31:0], work_q[30:0], 1'b1};
    is_div    = op_is_div(op_q);
    neg_hi    = is_div & sign_a_q;
    neg_lo    = is_div & (sign_a_q ^ sign_b_q) & ~dz_q;
    step      = is_div ? div_next : mul_next;
    accept_op = ~(op[2] & op[1]);
`else
    is_div    = 1'b0;
    neg_hi    = 1'b0;
    neg_lo    = 1'b0;
    step      = mul_next;
    accept_op = ~(op[2] & op[1]) & ~op_is_div(op);
`endif
    neg_full  = ~is_div & (sign_a_q ^ sign_b_q);
  end

  // Sequencer: start/flush handling, iteration countdown and HI/LO commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef HILO_DIV_EN
    dz_d     = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (accept_op) begin
            state_d  = ST_RUN;
            cnt_d    = CNT_W'(ITER - 1);
            op_d     = op;
            sign_a_d = sf_sign_a;
            sign_b_d = sf_sign_b;
`ifdef HILO_DIV_EN
            dz_d     = op_is_div(op) && (b == 32'd0);
            if (op_is_div(op)) begin
              work_d = {32'd0, mag_a};
              dvsr_d = mag_b;
            end else begin
              work_d = {32'd0, mag_b};
              dvsr_d = mag_a;
            end
`else
            work_d   = {32'd0, mag_b};
            dvsr_d   = mag_a;
`endif
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          work_d = step;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          case (op_q)
            OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + fixed;
            OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - fixed;
            default: {hi_d, lo_d} = fixed;
          endcase
`ifdef HILO_DIV_EN
          if (dz_q) lo_d = 32'hFFFF_FFFF;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and HI/LO registers; async reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef HILO_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef HILO_DIV_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy & (start | hilo_read);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench for the HI/LO multiply/divide unit.
// Expected {hi,lo} commits are queued at issue; a negedge monitor pops on done.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hilo_read = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_read (hilo_read),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no commit", hi, lo);
      end else begin
        chk("hilo_commit", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n;
    sb.push_back({eh, el});
    issue(o, x, y);
    wait_idle(n);
    chk({name, "_latency"}, 64'(n), 64'd33);
    m_hi = eh; m_lo = el;
    @(negedge clk);
    chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int stall_bad;
    int done_seen;

    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, stall}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -2 x 7, with an ignored Start (MTHI) while busy
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF2});
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h0000_0123;
    #1 chk("stall_on_start", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("mult_latency", 64'(n + 5), 64'd33);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF2;
    @(negedge clk);
    chk("mult_done_pulse", {63'd0, done}, 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

`ifdef HILO_DIV_EN
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_m7_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
    issue(OP_DIV, 32'd9, 32'd3);
    chk("div_noop_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("div_noop_done", {63'd0, done}, 64'd0);
    chk("div_noop_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    // MTHI / MTLO single-edge writes
    issue(OP_MTHI, 32'd5, 32'd0);
    chk("mthi", {32'd0, hi}, 64'd5);
    chk("mthi_busy", {62'd0, busy, done}, 64'd0);
    issue(OP_MTLO, 32'd10, 32'd0);
    chk("mtlo", {hi, lo}, {32'd5, 32'd10});
    m_hi = 32'd5; m_lo = 32'd10;

    run_op("madd", OP_MADD, 32'd3, 32'd4, 32'd5, 32'd22);
    run_op("msub", OP_MSUB, 32'd3, 32'd4, 32'd5, 32'd10);
    run_op("madd_neg", OP_MADD, 32'hFFFF_FFFE, 32'd3, 32'd5, 32'd4);

    // Back-to-back: second Start in the Done cycle
    sb.push_back({32'd0, 32'd6});
    issue(OP_MULT, 32'd2, 32'd3);
    wait_idle(n);
    chk("b2b_first_latency", 64'(n), 64'd33);
    run_op("b2b_second", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

    // Stall tracks hilo_read from cycle 10 until busy falls
    sb.push_back({32'd0, 32'd6});
    issue(OP_MULT, 32'd2, 32'd3);
    stall_bad = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k == 10) hilo_read = 1'b1;
      #1;
      if (stall !== ((k >= 10 && k <= 33) ? 1'b1 : 1'b0)) stall_bad++;
      if (k < 34) @(negedge clk);
    end
    chk("stall_track", 64'(stall_bad), 64'd0);
    hilo_read = 1'b0;
    m_hi = 32'd0; m_lo = 32'd6;
    @(negedge clk);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Flush at cycle 12: no commit, HI/LO untouched
    issue(OP_MULT, 32'd7, 32'd7);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush beats a coincident Start
    start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);

    // Async reset mid-RUN clears state without a clock edge
    issue(OP_MULT, 32'd7, 32'd7);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_flags", {61'd0, busy, done, stall}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    run_op("mult_3x3", OP_MULT, 32'd3, 32'd3, 32'd0, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
